zuc_sbox_pipe: RTL

//  Parametrised, pipelined multi-lane byte-substitution unit for the ZUC nonlinear function F.

---
 rtl/zuc_sbox_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/zuc_sbox_pipe.sv
// Multi-lane ZUC S-box substitution stage with a valid/ready elastic pipeline.
// One or two register stages; lanes are independent 32-bit words.
module zuc_sbox_pipe #(
    parameter int LANES       = 2,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [32*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data,
    output logic [CNT_W-1:0]      xfer_cnt
);

    localparam int DW = 32 * LANES;

    // NOTE: the tables are constants, so they synthesise to ROM/logic and need no reset.
    localparam logic [0:255][7:0] S0 = {
        128'h3e725b47_cae00033_04d15498_09b96dcb, 128'h7b1bf932_af9d6aa5_b82dfc1d_08530390,
        128'h4d4e8499_e4ced991_ddb68548_8b296eac, 128'hcdc1f81e_734369c6_b5bdfd39_6320d438,
        128'h767db2a7_cfed57c5_f32cbb14_2106559b, 128'he3ef5e31_4f7f5aa4_0d825149_5fba581c,
        128'h4a16d517_a892241f_8cffd8ae_2e01d3ad, 128'h3b4bda46_ebc9de9a_8f87d73a_806f2fc8,
        128'hb1b437f7_0a221328_7ccc3c89_c7c39656, 128'h07bf7ef0_0b2b9752_35417961_a64c10fe,
        128'hbc269588_8ab0a3fb_c01894f2_e1e5e95d, 128'hd0dc1166_645cec59_427512f5_749caa23,
        128'h0e86abbe_2a02e767_e644a26c_c2939ff1, 128'hf6fa36d2_50689e62_71153dd6_40c4e20f,
        128'h8e83776b_25053f0c_30ea70b7_a1e8a965, 128'h8d271adb_81b3a0f4_457a19df_ee783460
    };

    localparam logic [0:255][7:0] S1 = {
        128'h55c26371_3bc84786_9f3cda5b_29aafd77, 128'h8cc5940c_a61a1300_e3a81672_40f9f842,
        128'h44266896_81d9453e_1076c6a7_8b3943e1, 128'h3ab5562a_c06db305_2266bfdc_0bfa6248,
        128'hdd201106_36c9c1cf_f62752bb_69f5d487, 128'h7f844cd2_9c57a4bc_4f9adffe_d68d7aeb,
        128'h2b53d85c_a11417fb_23d57d30_67730809, 128'heeb7703f_61b2198e_4ee54b93_8f5ddba9,
        128'hadf1ae2e_cb0dfcf4_2d466e1d_97e8d1e9, 128'h4d37a575_5e839eab_829db91c_e0cd4989,
        128'h01b6bd58_24a25f38_78991590_50b895e4, 128'hd091c7ce_ed0fb46f_a0ccf002_4a79c3de,
        128'ha3efea51_e66b18ec_1b2c80f7_74e7ff21, 128'h5a6a541e_41319235_c433070a_ba7e0e34,
        128'h88b1987c_f33d606c_7bcad31f_32650428, 128'h64be859b_2f598ad7_b025acaf_1203e2f2
    };

    // Even bytes use S1 in ZUC mode; mode 1 forces S0 everywhere.
    function automatic logic [DW-1:0] f_subst(input logic [DW-1:0] data, input logic mode);
        logic [DW-1:0] res;
        res = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (!j[0] && !mode)
                    res[32*k+8*j +: 8] = S1[data[32*k+8*j +: 8]];
                else
                    res[32*k+8*j +: 8] = S0[data[32*k+8*j +: 8]];
            end
        end
        return res;
    endfunction

    logic            r_vb;
    logic [DW-1:0]   r_db;
    logic [CNT_W-1:0] r_cnt;
    logic            w_load_b;
    logic            w_src_valid;
    logic [DW-1:0]   w_src_data;
    logic            w_in_ready;

    assign w_load_b = ~r_vb | out_ready;

    generate
        if (PIPE_STAGES == 1) begin : g_pipe1
            assign w_src_valid = in_valid;
            assign w_src_data  = f_subst(in_data, in_mode);
            assign w_in_ready  = w_load_b;
        end else if (PIPE_STAGES == 2) begin : g_pipe2
            logic          r_va;
            logic [DW-1:0] r_da;
            logic          r_ma;
            logic          w_load_a;

            assign w_load_a    = ~r_va | w_load_b;
            assign w_src_valid = r_va;
            assign w_src_data  = f_subst(r_da, r_ma);
            assign w_in_ready  = w_load_a;

            // Mode is captured alongside its word so later in_mode changes cannot leak in.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_va <= 1'b0;
                    r_da <= '0;
                    r_ma <= 1'b0;
                end else if (w_load_a) begin
                    r_va <= in_valid;
                    if (in_valid) begin
                        r_da <= in_data;
                        r_ma <= in_mode;
                    end
                end
            end
        end else begin : g_bad_pipe
            $error("zuc_sbox_pipe: PIPE_STAGES must be 1 or 2");
        end
    endgenerate

    // Output stage: holds its word while stalled, refills on the same edge it drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vb <= 1'b0;
            r_db <= '0;
        end else if (w_load_b) begin
            r_vb <= w_src_valid;
            if (w_src_valid)
                r_db <= w_src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_vb && out_ready)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_vb;
    assign out_data  = r_db;
    assign xfer_cnt  = r_cnt;

endmodule
